reg_dump_tx: RTL
================

Name: reg_dump_tx

Overview:
- Debug read-out engine for the single-cycle MIPS core's register-file observe port.
- The core supplies the data side: observe[4:0] selects a register and data_ob returns its value.
- This block drives observe itself, walking registers 0..LAST_REG, and snapshots each 32-bit value.
- Each register goes out on a UART 8N1 line as a 5-byte record: the index byte, then 4 data bytes, most significant byte first. The block sits beside the core top-level in the board wrapper.

Parameters:
- CLKS_PER_BIT, 16, CLK cycles per UART bit; legal range 2..65535.
- LAST_REG, 31, highest register index dumped; legal range 0..31.

Ports:
- CLK  input  1  system clock; every state change happens on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level sampled on CLK; a high level in IDLE begins a dump.
- observe  output  5  register-select index presented to the core's observe port.
- data_ob  input  32  register value returned by the core for the current observe.
- tx  output  1  UART serial output; idles high.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the last stop bit has completed.

Behaviour:
- Reset, applied asynchronously at any time, sets: observe=0, tx=1, busy=0, done=0, state=IDLE, all counters 0, shift register 0.
- IDLE:
  - tx=1, busy=0.
  - When start=1 at a rising edge: go to SELECT, set observe=0, set busy=1 from the next cycle.
  - start is ignored in every other state; there is no queueing.
- SELECT (1 cycle): observe holds the current index so data_ob settles a full cycle.
- LATCH (1 cycle):
  - Capture data_ob into a 32-bit snapshot.
  - Load the byte buffer with {3'b000, observe}.
  - Set byte count to 0.
  - Later changes on data_ob do not affect this record.
- SEND (10*CLKS_PER_BIT cycles per byte):
  - Bit order: start bit 0, data bits LSB first, stop bit 1.
  - Each bit holds tx for exactly CLKS_PER_BIT cycles.
  - After a stop bit, if bytes sent < 5, load the next byte immediately with no idle gap. Byte order: snapshot[31:24], [23:16], [15:8], [7:0].
  - After the 5th stop bit, go to NEXT.
- NEXT (0 extra cycles, folded into the last stop-bit cycle):
  - If observe < LAST_REG: increment observe and go to SELECT.
  - Otherwise: go to DONE.
- DONE (1 cycle): done=1, busy stays 1, tx=1, then go to IDLE with busy=0.
  - observe keeps its final value until the next start or reset.
- Timing:
  - Per-register cost is 2 + 50*CLKS_PER_BIT cycles.
  - done asserts (LAST_REG+1)*(2+50*CLKS_PER_BIT) cycles after the first SELECT cycle.
  - The first SELECT cycle is the cycle after start is sampled.
- The bit-period counter is width-sized for CLKS_PER_BIT-1.
- observe never exceeds LAST_REG and never wraps during a dump.
- If start is still high in the IDLE cycle right after DONE, a new dump starts.
- Reset mid-byte: tx returns to 1 asynchronously. The partial frame is abandoned and a receiver sees a framing error. The block does not resume.

Test Plan:
- Reset: assert reset mid-simulation with no clock edge -> observe=0, tx=1, busy=0, done=0 immediately.
- Single record, CLKS_PER_BIT=4, LAST_REG=0, data_ob=32'h12345678 -> tx bytes 0x00,0x12,0x34,0x56,0x78, each LSB first with correct start/stop bits; done pulses exactly 202 cycles after the first SELECT.
- Full dump, CLKS_PER_BIT=4, data_ob modelled as {27'b0,observe}+32'hA0000000 -> 32 records with index i and data A0_00_00_i in order; done at 32*202=6464 cycles; busy high throughout.
- Snapshot isolation: data_ob changed to 32'hFFFFFFFF during SEND of register 3 -> register 3's record still carries the value latched in LATCH.
- start held high and pulsed repeatedly while busy -> no restart; observe sequence is strictly 0..LAST_REG.
- Reset asserted during bit 4 of the data byte of register 7 -> tx=1 at once, busy=0. A new start then dumps from register 0 with a correct first record.

Source files
------------

// File: rtl/reg_dump_tx.sv
// Register-file dump engine: walks observe over 0..LAST_REG, snapshots data_ob and
// streams each register as a 5-byte UART 8N1 record (index, then data MSB first).
module reg_dump_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int LAST_REG     = 31
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  observe,
  input  logic [31:0] data_ob,
  output logic        tx,
  output logic        busy,
  output logic        done
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, SELECT, LATCH, SEND, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  clk_cnt;
  logic [3:0]        bit_idx;
  logic [2:0]        byte_cnt;
  logic [8:0]        shreg;
  logic [31:0]       snap;
  logic [7:0]        next_byte;
  logic              bit_end, frame_end, rec_end, more_regs;

  assign bit_end   = (state == SEND) && (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign frame_end = bit_end && (bit_idx == 4'd9);
  assign rec_end   = frame_end && (byte_cnt == 3'd4);
  assign more_regs = observe < 5'(LAST_REG);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SELECT;
      SELECT:  state_nxt = LATCH;
      LATCH:   state_nxt = SEND;
      SEND:    if (rec_end) state_nxt = more_regs ? SELECT : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // byte_cnt names the byte now on the wire; pick the one that follows it
  always_comb begin
    next_byte = snap[31:24];
    case (byte_cnt)
      3'd1:    next_byte = snap[23:16];
      3'd2:    next_byte = snap[15:8];
      3'd3:    next_byte = snap[7:0];
      default: next_byte = snap[31:24];
    endcase
  end

  // shreg carries {stop, data}; tx is registered so each bit starts exactly on an edge
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      observe  <= '0;
      tx       <= 1'b1;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      snap     <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          clk_cnt <= '0;
          if (start) observe <= '0;
        end
        LATCH: begin
          snap     <= data_ob;
          shreg    <= {1'b1, 3'b000, observe};
          byte_cnt <= '0;
          bit_idx  <= '0;
          clk_cnt  <= '0;
          tx       <= 1'b0;
        end
        SEND: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx != 4'd9) begin
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[8:1]};
              bit_idx <= bit_idx + 4'd1;
            end else if (byte_cnt != 3'd4) begin
              byte_cnt <= byte_cnt + 3'd1;
              shreg    <= {1'b1, next_byte};
              bit_idx  <= '0;
              tx       <= 1'b0;
            end else begin
              tx <= 1'b1;
              if (more_regs) observe <= observe + 5'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        default: tx <= 1'b1;
      endcase
    end
  end
endmodule
